fede_seq: RTL
=============

# fede_seq

Multi-cycle sequencer for the fetch/decode datapath. Drives the instruction address (`pc`/`dir`) into instruction memory, strobes the instruction register, classifies the decoded opcode, and issues the register-bank write enable (`regWrite`-equivalent) and ALU operation code once per instruction. It sits between the top-level run control and the FEDE datapath, replacing free-running PC stepping with an explicit FETCH → DECODE → EXEC → WB schedule.

## Interface
- `PC_W`, 7: width of `pc`/`dir`, byte address.
- `RESET_PC`, 0: `pc` value after reset; must be a multiple of 4.
- `MEM_LAT`, 1: instruction-memory read latency in cycles, legal range 1..4.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `run`  in  1: sequencing enable.
- `opcode`  in  6: instruction bits [31:26]; valid during DECODE.
- `funct`  in  6: instruction bits [5:0]; valid during DECODE.
- `pc`  out  PC_W: address of the current instruction.
- `dir`  out  PC_W: instruction-memory address.
- `ir_we`  out  1: instruction-register load strobe.
- `reg_write`  out  1: register-bank write enable.
- `alu_op`  out  2: 00 add, 01 sub, 10 use `funct`.
- `busy`  out  1: high in any state other than IDLE.
- `illegal`  out  1: sticky unsupported-opcode flag.
- `instr_count`  out  16: retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB. All outputs are registered or decoded from registered state. There are no combinational input-to-output paths.
- IDLE: if `run`=1, go to FETCH and load the latency counter with MEM_LAT-1. Otherwise hold.
- FETCH: `dir`=`pc` for every cycle. Count down. On the cycle the counter reaches 0, `ir_we`=1 and the next state is DECODE.
- DECODE: sample `opcode`/`funct` into internal registers.
  - opcode 6'h00 (R-type) → `alu_op`=10, go to EXEC.
  - opcode 6'h08 (addi) → `alu_op`=00, go to EXEC.
  - opcode 6'h04 (beq) → `alu_op`=01, go to EXEC with write suppressed.
  - Any other opcode: set `illegal`, `pc`←`pc`+4, no EXEC/WB. Go to FETCH if `run`, else IDLE.
- EXEC: one cycle. `alu_op` is held.
- WB: one cycle.
  - `reg_write`=1, except for beq.
  - `alu_op` is held.
  - `pc`←`pc`+4.
  - `instr_count`←`instr_count`+1.
  - Next state is FETCH if `run`, else IDLE.
- PC arithmetic is modulo 2^PC_W, so it wraps silently (e.g. 124+4 → 0 at PC_W=7).
- `instr_count` wraps 0xFFFF → 0.
- `illegal` is cleared only by `rst`.
- `run` deasserted mid-instruction: the current instruction completes through WB (or the illegal skip), then the FSM enters IDLE. `run` is sampled only at IDLE and at instruction end.

## Timing
- Reset values:
  - State IDLE.
  - `pc`=`dir`=RESET_PC.
  - `ir_we`=0, `reg_write`=0, `alu_op`=00.
  - `busy`=0, `illegal`=0, `instr_count`=0.
- `rst` has priority over everything, including mid-instruction. On the edge after `rst`=1 all reset values hold. No pending `reg_write` pulse, PC increment or count update escapes.
- Cycles per legal instruction: MEM_LAT+3. Illegal instruction: MEM_LAT+1.
- `ir_we` and `reg_write` are single-cycle pulses, exactly one per instruction.
- New `pc` is visible the cycle after WB, or after DECODE for an illegal opcode. That cycle is the first FETCH cycle of the next instruction.
- Back-to-back with `run` held at 1: no idle cycles between instructions.

## Configuration
- `FEDE_SEQ_COUNT_EN` defined: `instr_count` register and incrementer are built as described.
- `FEDE_SEQ_COUNT_EN` undefined: the register is not built and `instr_count` is tied to 16'd0. All other behaviour is identical.

## Test plan
- Reset: `rst`=1 for 2 cycles, `run`=0 → `pc`=`dir`=0, `busy`=0, `ir_we`=`reg_write`=0, `illegal`=0, `instr_count`=0.
- R-type add, MEM_LAT=1: `run`=1, opcode 0x00, funct 0x20 → `ir_we` in cycle 1, `alu_op`=10 in cycles 3–4, `reg_write` in cycle 4 only, then `pc`=4 and `instr_count`=1.
- addi then beq back-to-back → addi gives `alu_op`=00 and a `reg_write` pulse. beq gives `alu_op`=01 and no `reg_write`. `pc` goes 0→4→8 in 8 cycles; `instr_count`=2.
- Illegal opcode 0x3F → `illegal`=1 and stays set, no `reg_write`, `pc` advances by 4 after 2 cycles, `instr_count` unchanged.
- Wrap and run drop: RESET_PC=124, PC_W=7. Deassert `run` during EXEC → WB completes, `pc`=0, FSM in IDLE, `busy`=0.
- Reset mid-op: `rst` asserted during EXEC → next cycle IDLE, `pc`=RESET_PC, `reg_write` never asserted for that instruction.

Source files
------------

// File: rtl/fede_seq.sv
// fede_seq: FETCH/DECODE/EXEC/WB sequencer; MEM_LAT+3 cycles per legal instruction, MEM_LAT+1 per illegal, no backpressure (run gates instruction starts).
// Define FEDE_SEQ_COUNT_EN to build the retired-instruction counter; otherwise instr_count is tied to zero.
module fede_seq #(
  parameter int PC_W     = 7,
  parameter int RESET_PC = 0,
  parameter int MEM_LAT  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [5:0]      opcode,
  input  logic [5:0]      funct,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] dir,
  output logic            ir_we,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic            busy,
  output logic            illegal,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  state_t            state, next;
  logic [1:0]        lat_cnt;
  logic [PC_W-1:0]   pc_q;
  logic [1:0]        alu_q;
  logic              beq_q;
  logic              illegal_q;
  logic              legal;

  // funct only matters to the downstream ALU decoder when alu_op selects it
  logic unused_funct;
  assign unused_funct = ^funct;

  assign legal = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_BEQ);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (run) next = FETCH;
      FETCH:   if (lat_cnt == 2'd0) next = DECODE;
      DECODE:  if (legal) next = EXEC;
               else       next = run ? FETCH : IDLE;
      EXEC:    next = WB;
      WB:      next = run ? FETCH : IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt   <= 2'd0;
      pc_q      <= PC_W'(RESET_PC);
      alu_q     <= 2'b00;
      beq_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // every entry into FETCH restarts the memory-latency countdown
      if (next == FETCH && state != FETCH)
        lat_cnt <= 2'(MEM_LAT - 1);
      else if (state == FETCH && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;

      if (state == DECODE) begin
        if (legal) begin
          alu_q <= (opcode == OP_RTYPE) ? 2'b10 :
                   (opcode == OP_BEQ)   ? 2'b01 : 2'b00;
          beq_q <= (opcode == OP_BEQ);
        end else begin
          illegal_q <= 1'b1;
          pc_q      <= pc_q + PC_W'(4);
        end
      end

      if (state == WB)
        pc_q <= pc_q + PC_W'(4);
    end
  end

`ifdef FEDE_SEQ_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)              count_q <= 16'd0;
    else if (state == WB) count_q <= count_q + 16'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 16'd0;
`endif

  always_comb begin
    pc        = pc_q;
    dir       = pc_q;
    ir_we     = (state == FETCH) && (lat_cnt == 2'd0);
    reg_write = (state == WB) && !beq_q;
    alu_op    = alu_q;
    busy      = (state != IDLE);
    illegal   = illegal_q;
  end

endmodule
